// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between Icache BURST_LEN-word line fills and Dcache single-word accesses.
// Grant/M_en follow a sampled request by 1 cycle; each word waits on M_ready indefinitely; ARB_RR_EN selects round-robin ties (default: D wins).
module mem_bus_arbiter #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  localparam int CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_req,
  input  logic [DATA_W-1:0] I_addr,
  output logic              I_grant,
  output logic              I_valid,
  output logic [DATA_W-1:0] I_rdata,
  output logic [CNT_W-1:0]  I_word,
  output logic              I_done,
  input  logic              D_req,
  input  logic              D_we,
  input  logic [DATA_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic              D_grant,
  output logic [DATA_W-1:0] D_rdata,
  output logic              D_done,
  output logic              M_en,
  output logic              M_we,
  output logic [DATA_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_wdata,
  input  logic [DATA_W-1:0] M_rdata,
  input  logic              M_ready
);

  localparam logic [DATA_W-1:0] LINE_MASK = ~DATA_W'(BURST_LEN * 4 - 1);
  localparam logic [DATA_W-1:0] WORD_MASK = ~DATA_W'(3);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  state_t            state, state_nxt;
  src_t              last_served, last_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_wrap;
  logic [DATA_W-1:0] line_base, base_nxt;
  logic [DATA_W-1:0] fill_addr;
  logic              tie_to_d;
  logic              pick_d;

  logic              i_grant_nxt, i_valid_nxt, i_done_nxt;
  logic [DATA_W-1:0] i_rdata_nxt;
  logic [CNT_W-1:0]  i_word_nxt;
  logic              d_grant_nxt, d_done_nxt;
  logic [DATA_W-1:0] d_rdata_nxt;
  logic              m_en_nxt, m_we_nxt;
  logic [DATA_W-1:0] m_addr_nxt, m_wdata_nxt;

`ifdef ARB_RR_EN
  assign tie_to_d = (last_served == SRC_I);
`else
  logic unused_last_served;
  assign tie_to_d           = 1'b1;
  assign unused_last_served = last_served;
`endif

  assign pick_d    = D_req && (!I_req || tie_to_d);
  assign cnt_wrap  = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  assign fill_addr = line_base + (DATA_W'(cnt) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= SRC_I;
      cnt         <= '0;
      line_base   <= '0;
      I_grant     <= 1'b0;
      I_valid     <= 1'b0;
      I_rdata     <= '0;
      I_word      <= '0;
      I_done      <= 1'b0;
      D_grant     <= 1'b0;
      D_rdata     <= '0;
      D_done      <= 1'b0;
      M_en        <= 1'b0;
      M_we        <= 1'b0;
      M_addr      <= '0;
      M_wdata     <= '0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      cnt         <= cnt_nxt;
      line_base   <= base_nxt;
      I_grant     <= i_grant_nxt;
      I_valid     <= i_valid_nxt;
      I_rdata     <= i_rdata_nxt;
      I_word      <= i_word_nxt;
      I_done      <= i_done_nxt;
      D_grant     <= d_grant_nxt;
      D_rdata     <= d_rdata_nxt;
      D_done      <= d_done_nxt;
      M_en        <= m_en_nxt;
      M_we        <= m_we_nxt;
      M_addr      <= m_addr_nxt;
      M_wdata     <= m_wdata_nxt;
    end
  end

  // Each word is an M_en phase followed by one M_en-low phase carrying the
  // valid/done pulse; the low phase after the last word returns to IDLE.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last_served;
    cnt_nxt     = cnt;
    base_nxt    = line_base;
    i_grant_nxt = I_grant;
    i_valid_nxt = 1'b0;
    i_rdata_nxt = I_rdata;
    i_word_nxt  = I_word;
    i_done_nxt  = 1'b0;
    d_grant_nxt = D_grant;
    d_rdata_nxt = D_rdata;
    d_done_nxt  = 1'b0;
    m_en_nxt    = M_en;
    m_we_nxt    = M_we;
    m_addr_nxt  = M_addr;
    m_wdata_nxt = M_wdata;

    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt   = SERVE_D;
          last_nxt    = SRC_D;
          d_grant_nxt = 1'b1;
          m_en_nxt    = 1'b1;
          m_we_nxt    = D_we;
          m_addr_nxt  = D_addr & WORD_MASK;
          m_wdata_nxt = D_wdata;
        end else if (I_req) begin
          state_nxt   = SERVE_I;
          last_nxt    = SRC_I;
          cnt_nxt     = '0;
          base_nxt    = I_addr & LINE_MASK;
          i_grant_nxt = 1'b1;
          m_en_nxt    = 1'b1;
          m_we_nxt    = 1'b0;
          m_addr_nxt  = I_addr & LINE_MASK;
        end
      end

      SERVE_I: begin
        if (M_en) begin
          if (M_ready) begin
            m_en_nxt    = 1'b0;
            i_valid_nxt = 1'b1;
            i_rdata_nxt = M_rdata;
            i_word_nxt  = cnt;
            i_done_nxt  = (cnt == CNT_LAST);
            cnt_nxt     = cnt_wrap;
          end
        end else if (cnt == '0) begin
          // Counter has wrapped: the final word was returned last cycle.
          state_nxt   = IDLE;
          i_grant_nxt = 1'b0;
          m_addr_nxt  = '0;
        end else begin
          m_en_nxt    = 1'b1;
          m_addr_nxt  = fill_addr;
        end
      end

      SERVE_D: begin
        if (M_en) begin
          if (M_ready) begin
            m_en_nxt   = 1'b0;
            m_we_nxt   = 1'b0;
            d_done_nxt = 1'b1;
            if (!M_we) begin
              d_rdata_nxt = M_rdata;
            end
          end
        end else begin
          state_nxt   = IDLE;
          d_grant_nxt = 1'b0;
          m_addr_nxt  = '0;
          m_wdata_nxt = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected memory accesses, returns and grant lengths;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_bus_arbiter;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          I_req;
  logic [DW-1:0] I_addr;
  logic          I_grant, I_valid, I_done;
  logic [DW-1:0] I_rdata;
  logic [CW-1:0] I_word;
  logic          D_req, D_we;
  logic [DW-1:0] D_addr, D_wdata;
  logic          D_grant, D_done;
  logic [DW-1:0] D_rdata;
  logic          M_en, M_we;
  logic [DW-1:0] M_addr, M_wdata, M_rdata;
  logic          M_ready;

  mem_bus_arbiter #(.DATA_W(DW), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .I_req(I_req), .I_addr(I_addr), .I_grant(I_grant), .I_valid(I_valid),
    .I_rdata(I_rdata), .I_word(I_word), .I_done(I_done),
    .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_grant(D_grant), .D_rdata(D_rdata), .D_done(D_done),
    .M_en(M_en), .M_we(M_we), .M_addr(M_addr), .M_wdata(M_wdata),
    .M_rdata(M_rdata), .M_ready(M_ready)
  );

  initial forever #5 clk = ~clk;

  // Memory contents: 0x40 holds 0x11, every other word reads back F00D:<low address half>.
  assign M_rdata = (M_addr == 32'h0000_0040) ? 32'h0000_0011 : {16'hF00D, M_addr[15:0]};

  typedef struct { logic [DW-1:0] addr; logic we; logic [DW-1:0] wdata; int cyc; } mexp_t;
  typedef struct { logic [DW-1:0] rdata; logic [CW-1:0] word; logic done; } iexp_t;
  typedef struct { logic we; logic [DW-1:0] rdata; } dexp_t;

  mexp_t exp_m[$];
  iexp_t exp_i[$];
  dexp_t exp_d[$];
  int    exp_ig[$];
  int    exp_dg[$];

  int errors = 0;
  int checks = 0;

  logic          chk_quiet, tight, end_req, idle_mode, d_again;
  logic [DW-1:0] d_next;
  logic [7:0]    idle_pat;
  int            pat_i, wait_n, wcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_m(input logic [DW-1:0] a, input logic we, input logic [DW-1:0] wd, input int cyc);
    mexp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.cyc = cyc;
    exp_m.push_back(e);
  endtask

  task automatic push_i(input logic [DW-1:0] rd, input logic [CW-1:0] w, input logic dn);
    iexp_t e;
    e.rdata = rd; e.word = w; e.done = dn;
    exp_i.push_back(e);
  endtask

  task automatic push_d(input logic we, input logic [DW-1:0] rd);
    dexp_t e;
    e.we = we; e.rdata = rd;
    exp_d.push_back(e);
  endtask

  // Full 4-word fill of a 16-byte line, zero wait states.
  task automatic push_burst(input logic [15:0] base);
    for (int w = 0; w < 4; w++) begin
      push_m({16'h0000, base + 16'(w * 4)}, 1'b0, '0, 1);
      push_i({16'hF00D, base + 16'(w * 4)}, CW'(w), (w == 3));
    end
  endtask

  // One clock: requester agents drop/renew requests on done, memory model drives M_ready.
  task automatic step();
    @(posedge clk);
    #1;
    if (I_done) I_req = 1'b0;
    if (D_done) begin
      if (d_again) begin
        D_addr  = d_next;
        d_again = 1'b0;
      end else begin
        D_req = 1'b0;
      end
    end
    if (idle_mode) begin
      M_ready = idle_pat[pat_i];
      pat_i   = (pat_i + 1) % 8;
    end else if (M_en) begin
      if (wcnt >= wait_n) begin
        M_ready = 1'b1;
        wcnt    = 0;
      end else begin
        M_ready = 1'b0;
        wcnt++;
      end
    end else begin
      M_ready = 1'b0;
      wcnt    = 0;
    end
  endtask

  // Monitor
  mexp_t me;
  iexp_t ie;
  dexp_t de;
  int    en_cyc = 0, ig_run = 0, dg_run = 0, gap = 100, cyc_cnt = 0, g_exp;
  logic  prev_ig = 1'b0, prev_dg = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (chk_quiet) begin
        chk("quiet_ctl", {I_grant, I_valid, I_done, I_word, D_grant, D_done, M_en, M_we}, 64'd0);
        chk("quiet_rdata", {I_rdata, D_rdata}, 64'd0);
        chk("quiet_mem", {M_addr, M_wdata}, 64'd0);
      end
      if (M_en) begin
        en_cyc++;
        chk("mem_pending", exp_m.size() != 0, 1);
        if (exp_m.size() != 0) begin
          me = exp_m[0];
          chk("m_addr", M_addr, me.addr);
          chk("m_we", M_we, me.we);
          if (me.we) chk("m_wdata", M_wdata, me.wdata);
          if (M_ready) begin
            chk("m_en_cycles", en_cyc, me.cyc);
            void'(exp_m.pop_front());
          end
        end
        if (M_ready) en_cyc = 0;
      end
      if (I_valid) begin
        chk("i_pending", exp_i.size() != 0, 1);
        if (exp_i.size() != 0) begin
          ie = exp_i.pop_front();
          chk("i_rdata", I_rdata, ie.rdata);
          chk("i_word", I_word, ie.word);
          chk("i_done", I_done, ie.done);
        end
      end
      if (I_done) chk("i_done_with_valid", I_valid, 1);
      if (D_done) begin
        chk("d_pending", exp_d.size() != 0, 1);
        if (exp_d.size() != 0) begin
          de = exp_d.pop_front();
          if (!de.we) chk("d_rdata", D_rdata, de.rdata);
        end
      end
      if (I_grant) ig_run++;
      else if (prev_ig) begin
        chk("ig_pending", exp_ig.size() != 0, 1);
        if (exp_ig.size() != 0) begin
          g_exp = exp_ig.pop_front();
          chk("i_grant_len", ig_run, g_exp);
        end
        ig_run = 0;
      end
      if (D_grant) dg_run++;
      else if (prev_dg) begin
        chk("dg_pending", exp_dg.size() != 0, 1);
        if (exp_dg.size() != 0) begin
          g_exp = exp_dg.pop_front();
          chk("d_grant_len", dg_run, g_exp);
        end
        dg_run = 0;
      end
      if ((I_grant && !prev_ig) || (D_grant && !prev_dg)) begin
        chk("single_grant", I_grant && D_grant, 0);
        if (tight) chk("idle_gap", gap, 1);
        else       chk("no_back_to_back", gap >= 1, 1);
        gap = 0;
      end else if (!I_grant && !D_grant) begin
        gap++;
      end
      prev_ig = I_grant;
      prev_dg = D_grant;
      if (end_req) begin
        chk("left_mem", exp_m.size(), 0);
        chk("left_i", exp_i.size(), 0);
        chk("left_d", exp_d.size(), 0);
        chk("left_ig", exp_ig.size(), 0);
        chk("left_dg", exp_dg.size(), 0);
        chk("end_idle", {I_grant, D_grant, M_en}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (cyc_cnt > 3000) begin
        errors++;
        checks++;
        $display("FAIL watchdog: %0d cycles elapsed, limit 3000", cyc_cnt);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; I_req = 1'b0; I_addr = '0; D_req = 1'b0; D_we = 1'b0;
    D_addr = '0; D_wdata = '0; M_ready = 1'b0;
    chk_quiet = 1'b0; tight = 1'b0; end_req = 1'b0; idle_mode = 1'b0;
    d_again = 1'b0; d_next = '0; idle_pat = 8'b1011_0110; pat_i = 0; wait_n = 0; wcnt = 0;

    // Reset state, then an idle bus with stray M_ready pulses.
    step(); step();
    chk_quiet = 1'b1;
    step();
    rst = 1'b0;
    idle_mode = 1'b1;
    repeat (8) step();
    idle_mode = 1'b0;
    step();
    chk_quiet = 1'b0;

    // Line fill from a mid-line miss address, zero wait states.
    push_burst(16'h1230);
    exp_ig.push_back(8);
    I_addr = 32'h0000_1234;
    I_req  = 1'b1;
    repeat (12) step();

    // Dcache write with 3 wait states.
    push_m(32'h0000_8004, 1'b1, 32'hDEAD_BEEF, 4);
    push_d(1'b1, '0);
    exp_dg.push_back(5);
    wait_n  = 3;
    D_we    = 1'b1;
    D_addr  = 32'h0000_8006;
    D_wdata = 32'hDEAD_BEEF;
    D_req   = 1'b1;
    repeat (10) step();

    // Simultaneous requests; D re-requests (0x48) right after its first read.
    wait_n  = 0;
    D_we    = 1'b0;
    D_addr  = 32'h0000_0040;
    D_wdata = '0;
    I_addr  = 32'h0000_2008;
    d_again = 1'b1;
    d_next  = 32'h0000_0048;
    push_m(32'h0000_0040, 1'b0, '0, 1);
`ifdef ARB_RR_EN
    push_burst(16'h2000);
    push_m(32'h0000_0048, 1'b0, '0, 1);
`else
    push_m(32'h0000_0048, 1'b0, '0, 1);
    push_burst(16'h2000);
`endif
    push_d(1'b0, 32'h0000_0011);
    push_d(1'b0, 32'hF00D_0048);
    exp_dg.push_back(2);
    exp_dg.push_back(2);
    exp_ig.push_back(8);
    I_req = 1'b1;
    D_req = 1'b1;
    step(); step();
    tight = 1'b1;
    repeat (20) step();
    tight = 1'b0;

    // Reset after the second word of a fill; the fill then restarts at word 0.
    push_m(32'h0000_3010, 1'b0, '0, 1);
    push_m(32'h0000_3014, 1'b0, '0, 1);
    push_i(32'hF00D_3010, 2'd0, 1'b0);
    push_i(32'hF00D_3014, 2'd1, 1'b0);
    exp_ig.push_back(4);
    push_burst(16'h3010);
    exp_ig.push_back(8);
    I_addr = 32'h0000_301C;
    I_req  = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_quiet = 1'b1;
    step();
    chk_quiet = 1'b0;
    repeat (12) step();

    // Dcache read whose request drops mid-access, 2 wait states.
    push_m(32'h0000_0100, 1'b0, '0, 3);
    push_d(1'b0, 32'hF00D_0100);
    exp_dg.push_back(4);
    wait_n = 2;
    D_we   = 1'b0;
    D_addr = 32'h0000_0100;
    D_req  = 1'b1;
    step(); step();
    D_req = 1'b0;
    repeat (10) step();

    end_req = 1'b1;
    repeat (5) step();
  end

endmodule
